multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main FSM of the multicycle RV32I subset core.
- Sequences the shared ALU, memory port, register file and PC/IR latches across cycles.
- Drives ImmSrc on the immediate extender, whose encoding is 000 I, 001 S, 010 B, 011 none, 100 U, 101 J.
- Decodes from the latched instruction register. Stalls on a single-ported memory through a req/ready handshake.

Parameters:
- Width, 32, instruction width. The instruction fields used are fixed RV32 positions.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Instr  in  Width  instruction register contents (op [6:0], funct3 [14:12], funct7b5 [30])
- Zero  in  1  ALU result == 0
- MemReady  in  1  memory completes the current request this cycle
- PCWrite  out  1  PC load enable
- IRWrite  out  1  IR and OldPC load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemReq  out  1  memory access request
- MemWrite  out  1  store strobe, qualified by MemReq
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmOp, 10 = constant 4
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt, 111 passB
- ImmSrc  out  3  immediate type select for the extender
- Illegal  out  1  sticky illegal-instruction flag
- State  out  4  current state, for debug

Behaviour:
- Single state register. On rst asserted, asynchronously: State = FETCH (0), Illegal = 0.
- All outputs are combinational from State, Instr, Zero and MemReady.
- Default output values: every enable 0, selects 00, ALUControl 000, ImmSrc 011.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRPC 12, LUI 13, TRAP 15.
- FETCH:
  - Outputs: MemReq=1, AdrSrc=0, SrcA=00, SrcB=10, add, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Holds while MemReady=0. Goes to DECODE on MemReady=1.
- DECODE:
  - Outputs: SrcA=01, SrcB=01, add; this latches the branch/jal target into ALUOut.
  - ImmSrc: B for branch, J for jal, otherwise 010.
  - Dispatch on op: lw 0000011 / sw 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; anything else -> TRAP.
  - Unsupported funct3 also goes to TRAP. Supported values: ALU 000/010/110/111; branch 000 (beq) / 001 (bne).
- MEMADR: SrcA=10, SrcB=01, add; ImmSrc = I for lw, S for sw. Goes to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: MemReq=1, AdrSrc=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Holds until MemReady, then goes to FETCH.
- EXECR:
  - Outputs: SrcA=10, SrcB=00.
  - ALUControl: funct3 000 gives sub if funct7b5=1, else add; 111 and; 110 or; 010 slt.
  - Goes to ALUWB.
- EXECI: SrcA=10, SrcB=01, ImmSrc=I. Same funct3 map as EXECR, with funct7b5 ignored (always add). Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH:
  - Outputs: SrcA=10, SrcB=00, sub, ResultSrc=00.
  - PCWrite = Zero for beq, ~Zero for bne.
  - Goes to FETCH.
- JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes the link value OldPC+4.
- JALR: SrcA=10, SrcB=01, ImmSrc=I, add. Goes to JALRPC.
- JALRPC: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB.
- LUI: SrcB=01, ImmSrc=U, passB. Goes to ALUWB.
- TRAP: Illegal=1, all other outputs at defaults. Absorbing state; only rst exits.
- MemReady outside a MemReq state is ignored.
- rst mid-access drops MemReq in the same cycle (asynchronous).

Test Plan:
- Reset, then lw x5,8(x1) with MemReady held 0 for 2 cycles in both FETCH and MEMREAD -> state trace 0,0,0,1,2,3,3,3,4,0. ImmSrc=000 in MEMADR. RegWrite=1 only in MEMWB.
- sw x2,4(x1) with MemReady=1 immediately -> trace 0,1,2,5,0. ImmSrc=001 in MEMADR. MemWrite=1 for exactly 1 cycle.
- beq with Zero=1, then bne with Zero=1 -> PCWrite=1 in BRANCH for beq, 0 for bne. ALUControl=001 in both.
- R-type sub (funct7b5=1, funct3=000) -> EXECR ALUControl=001. Same encoding as I-type (op 0010011) -> EXECI ALUControl=000.
- jal, then jalr -> traces 0,1,10,8,0 and 0,1,11,12,8,0. ImmSrc=101 in jal DECODE. PCWrite high once per instruction.
- Opcode 1111111 -> DECODE then TRAP, Illegal=1 held 10 cycles. Pulse rst mid-TRAP -> State=0 and Illegal=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface multicycle_ctrl_if #(
  parameter int unsigned Width = 32
);
  logic [Width-1:0] Instr;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             IRWrite;
  logic             AdrSrc;
  logic             MemReq;
  logic             MemWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic [2:0]       ImmSrc;
  logic             Illegal;
  logic [3:0]       State;

  // Controller side
  modport master (
    input  Instr, Zero, MemReady,
    output PCWrite, IRWrite, AdrSrc, MemReq, MemWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
  );

  // Datapath side
  modport slave (
    output Instr, Zero, MemReady,
    input  PCWrite, IRWrite, AdrSrc, MemReq, MemWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main FSM of the multicycle RV32I-subset core. Sequences the shared ALU,
// single-ported memory, register file and PC/IR latches; decodes from the IR.
module multicycle_ctrl (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrPc   = 4'd12,
    StLui      = 4'd13,
    StTrap     = 4'd15
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluPass = 3'b111;

  localparam logic [2:0] ImmI    = 3'b000;
  localparam logic [2:0] ImmS    = 3'b001;
  localparam logic [2:0] ImmB    = 3'b010;
  localparam logic [2:0] ImmNone = 3'b011;
  localparam logic [2:0] ImmU    = 3'b100;
  localparam logic [2:0] ImmJ    = 3'b101;

  state_e     state_q, state_d;
  logic       illegal_q;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       alu_f3_ok;
  logic       br_f3_ok;

  assign op       = bus.Instr[6:0];
  assign funct3   = bus.Instr[14:12];
  assign funct7b5 = bus.Instr[30];

  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);

  assign bus.State   = state_q;
  assign bus.Illegal = illegal_q;

  // State register and sticky illegal flag; both cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == StTrap);
    end
  end

  // Next-state and control outputs, decoded from state and the latched IR
  always_comb begin
    state_d        = state_q;
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemReq     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = AluAdd;
    bus.ImmSrc     = ImmNone;

    unique case (state_q)
      StFetch: begin
        bus.MemReq    = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
        if (bus.MemReady) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the PC-relative target into ALUOut while dispatching
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (op == OpJal) ? ImmJ : ImmB;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = alu_f3_ok ? StExecR : StTrap;
          OpIType:         state_d = alu_f3_ok ? StExecI : StTrap;
          OpBranch:        state_d = br_f3_ok ? StBranch : StTrap;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (op == OpStore) ? ImmS : ImmI;
        state_d     = (op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
        if (bus.MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
        if (bus.MemReady) state_d = StFetch;
      end
      StExecR, StExecI: begin
        bus.ALUSrcA = 2'b10;
        if (state_q == StExecI) begin
          bus.ALUSrcB = 2'b01;
          bus.ImmSrc  = ImmI;
        end
        case (funct3)
          3'b000:  bus.ALUControl = (state_q == StExecR && funct7b5) ? AluSub : AluAdd;
          3'b111:  bus.ALUControl = AluAnd;
          3'b110:  bus.ALUControl = AluOr;
          3'b010:  bus.ALUControl = AluSlt;
          default: bus.ALUControl = AluAdd;
        endcase
        state_d = StAluWb;
      end
      StAluWb: begin
        bus.RegWrite = 1'b1;
        state_d      = StFetch;
      end
      StBranch: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = AluSub;
        // funct3 000 is beq, 001 is bne; others never reach here
        bus.PCWrite    = (funct3 == 3'b000) ? bus.Zero : ~bus.Zero;
        state_d        = StFetch;
      end
      StJal, StJalrPc: begin
        // ALU computes the link value OldPC+4 while the PC takes ALUOut
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        state_d     = StAluWb;
      end
      StJalr: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = ImmI;
        state_d     = StJalrPc;
      end
      StLui: begin
        bus.ALUSrcB    = 2'b01;
        bus.ImmSrc     = ImmU;
        bus.ALUControl = AluPass;
        state_d        = StAluWb;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StTrap;
      end
    endcase
  end

endmodule
